// File: rtl/quad_dec.sv
// quad_dec: quadrature decoder turning encoder phases A/B into step/direction pulses and a wrapping position count.
// Ports: i_clk clock, i_rstn sync active-low reset, i_a/i_b async encoder phases,
//        i_clr clears o_cnt, i_err_clr clears sticky o_err,
//        o_step one-cycle step pulse, o_ud last direction (1=up), o_cnt position, o_err illegal-transition flag.
// Build option: define QDEC_X1_EN for x1 decoding (only S10->S00 up and S00->S10 down step); default is x4.
module quad_dec #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_clr,
    input  logic             i_err_clr,
    output logic             o_step,
    output logic             o_ud,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_err
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0] FL = FW'(FILT_LEN);

    // low two bits of each phase state are the filtered {A,B}
    typedef enum logic [2:0] {
        S00  = 3'b000,
        S01  = 3'b001,
        S11  = 3'b011,
        S10  = 3'b010,
        INIT = 3'b100
    } state_t;

    state_t st, nxt;
    logic [SYNC_STAGES-1:0] sa, sb;
    logic [1:0] sy, f;
    logic [FW-1:0] fc [2];
    logic [FW-1:0] stab;
    logic step_n, ud_n, err_n, up;

    assign sy = {sa[SYNC_STAGES-1], sb[SYNC_STAGES-1]};

    // position of a phase pair along the up sequence 00,01,11,10
    function automatic logic [1:0] gidx(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sa    <= '0;
            sb    <= '0;
            f     <= '0;
            fc[0] <= '0;
            fc[1] <= '0;
            stab  <= '0;
        end else begin
            sa <= {sa[SYNC_STAGES-2:0], i_a};
            sb <= {sb[SYNC_STAGES-2:0], i_b};
            for (int i = 0; i < 2; i++) begin
                if (sy[i] == f[i])
                    fc[i] <= '0;
                else if (fc[i] == FL) begin
                    f[i]  <= sy[i];
                    fc[i] <= '0;
                end else
                    fc[i] <= fc[i] + 1'b1;
            end
            // cycles both filters have been settled; releases INIT
            stab <= (sy != f) ? '0 : (stab == FL) ? stab : stab + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            st     <= INIT;
            o_step <= 1'b0;
            o_ud   <= 1'b1;
            o_cnt  <= '0;
            o_err  <= 1'b0;
        end else begin
            st     <= nxt;
            o_step <= step_n;
            o_ud   <= ud_n;
            o_cnt  <= i_clr ? '0 : step_n ? (ud_n ? o_cnt + 1'b1 : o_cnt - 1'b1) : o_cnt;
            o_err  <= err_n | (o_err & ~i_err_clr);
        end
    end

    always_comb begin
        nxt    = st;
        step_n = 1'b0;
        ud_n   = o_ud;
        err_n  = 1'b0;
        up     = gidx(f) == gidx(st[1:0]) + 2'd1;
        if (st == INIT) begin
            if (stab == FL) nxt = state_t'({1'b0, f});
        end else if (f != st[1:0]) begin
            nxt = state_t'({1'b0, f});
            if ((f ^ st[1:0]) == 2'b11)
                err_n = 1'b1;
            else begin
`ifdef QDEC_X1_EN
                step_n = (st == S10 && f == 2'b00) || (st == S00 && f == 2'b10);
`else
                step_n = 1'b1;
`endif
                ud_n = step_n ? up : o_ud;
            end
        end
    end
endmodule
